// File: rtl/vram_arb_pkg.sv
// Shared types and limits for the shadow-VRAM read arbiter.
//   arb_tag_t        : identifies which requester owns an in-flight read
//   MAX_READ_LATENCY : deepest RAM read latency the tag pipeline supports
package vram_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_VGC,
    TAG_HOST
  } arb_tag_t;

  localparam int unsigned MAX_READ_LATENCY = 3;

endpackage

// File: rtl/vram_tag_pipe.sv
// Tag shift register that tracks read ownership across the RAM latency.
// Ports:
//   clk     : clock
//   clr     : synchronous clear, flushes every stage to TAG_NONE
//   tag_in  : tag of the read issued this cycle (TAG_NONE when idle)
//   tag_out : tag whose data is on the RAM output this cycle
module vram_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     clr,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  arb_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// Shares one sdpram read port between the video scanner (absolute priority),
// the VGC fetcher and a host reader (round-robin between the two), routes
// returned words back to their issuer and flags secondary starvation.
// Ports:
//   clk_logic, system_reset      : clock, synchronous active-high reset
//   vid_rd_i/vid_addr_i          : single-cycle video read, never stalled
//   vid_data_o/vid_valid_o       : registered video return
//   vgc_*/host_*                 : level request + address, comb grant, registered return
//   mem_rd_o/mem_addr_o          : comb RAM read enable/address
//   mem_data_i                   : RAM data, READ_LATENCY cycles after mem_rd_o
//   starve_o                     : sticky starvation flag
module vram_read_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                  clk_logic,
  input  logic                  system_reset,
  input  logic                  vid_rd_i,
  input  logic [ADDR_WIDTH-1:0] vid_addr_i,
  output logic [31:0]           vid_data_o,
  output logic                  vid_valid_o,
  input  logic                  vgc_req_i,
  input  logic [ADDR_WIDTH-1:0] vgc_addr_i,
  output logic                  vgc_gnt_o,
  output logic [31:0]           vgc_data_o,
  output logic                  vgc_valid_o,
  input  logic                  host_req_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  output logic                  host_gnt_o,
  output logic [31:0]           host_data_o,
  output logic                  host_valid_o,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  output logic                  starve_o
);

  // Out-of-range latencies are clamped to what the tag pipe supports.
  localparam int unsigned PIPE_DEPTH =
    (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
    (READ_LATENCY < 1)                ? 1 : READ_LATENCY;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_tag_t         win;
  arb_tag_t         ret_tag;
  logic             last_sec;   // 0 = vgc granted last, 1 = host
  logic [CNT_W-1:0] vgc_cnt;
  logic [CNT_W-1:0] host_cnt;

  // Winner selection; nothing is issued while reset is held.
  always_comb begin
    win        = TAG_NONE;
    mem_rd_o   = 1'b0;
    mem_addr_o = '0;
    vgc_gnt_o  = 1'b0;
    host_gnt_o = 1'b0;
    if (!system_reset) begin
      if (vid_rd_i)                    win = TAG_VID;
      else if (vgc_req_i && host_req_i) win = last_sec ? TAG_VGC : TAG_HOST;
      else if (vgc_req_i)              win = TAG_VGC;
      else if (host_req_i)             win = TAG_HOST;
    end
    case (win)
      TAG_VID: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = vid_addr_i;
      end
      TAG_VGC: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = vgc_addr_i;
        vgc_gnt_o  = 1'b1;
      end
      TAG_HOST: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = host_addr_i;
        host_gnt_o = 1'b1;
      end
      default: ;
    endcase
  end

  vram_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk     (clk_logic),
    .clr     (system_reset),
    .tag_in  (win),
    .tag_out (ret_tag)
  );

  // Round-robin pointer only moves on secondary grants.
  always_ff @(posedge clk_logic) begin
    if (system_reset)          last_sec <= 1'b1;
    else if (win == TAG_VGC)   last_sec <= 1'b0;
    else if (win == TAG_HOST)  last_sec <= 1'b1;
  end

  // Starvation counters saturate; the flag latches until reset.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      vgc_cnt  <= '0;
      host_cnt <= '0;
      starve_o <= 1'b0;
    end else begin
      if (!vgc_req_i || vgc_gnt_o)    vgc_cnt <= '0;
      else if (vgc_cnt != CNT_MAX)    vgc_cnt <= vgc_cnt + CNT_W'(1);
      if (!host_req_i || host_gnt_o)  host_cnt <= '0;
      else if (host_cnt != CNT_MAX)   host_cnt <= host_cnt + CNT_W'(1);
      starve_o <= starve_o | (vgc_cnt == CNT_MAX) | (host_cnt == CNT_MAX);
    end
  end

  // Return routing: the tag at the end of the pipe owns mem_data_i.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      vid_data_o   <= '0;
      vgc_data_o   <= '0;
      host_data_o  <= '0;
      vid_valid_o  <= 1'b0;
      vgc_valid_o  <= 1'b0;
      host_valid_o <= 1'b0;
    end else begin
      vid_valid_o  <= (ret_tag == TAG_VID);
      vgc_valid_o  <= (ret_tag == TAG_VGC);
      host_valid_o <= (ret_tag == TAG_HOST);
      if (ret_tag == TAG_VID)  vid_data_o  <= mem_data_i;
      if (ret_tag == TAG_VGC)  vgc_data_o  <= mem_data_i;
      if (ret_tag == TAG_HOST) host_data_o <= mem_data_i;
    end
  end

endmodule
